// File: rtl/laserdrop_pkg.sv
// Shared constants for the laser link: packet headers, packet lengths,
// FTDI read strobe timing defaults and the packet reader state encoding.
package laserdrop_pkg;

    localparam logic [7:0] START_SEQ = 8'hA5;
    localparam logic [7:0] STOP_SEQ  = 8'h5A;
    localparam logic [7:0] ACK_SEQ   = 8'hC3;
    localparam logic [7:0] DONE_SEQ  = 8'h3C;

    localparam int START_PKT_LEN = 8;
    localparam int STOP_PKT_LEN  = 2;

    localparam int RD_LOW_CYCLES_DEF  = 2;
    localparam int RD_HIGH_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_LOW  = 2'd1,
        ST_RD_HIGH = 2'd2,
        ST_HOLD    = 2'd3
    } rd_state_e;

endpackage

// File: rtl/ftdi_pkt_reader_if.sv
// FTDI read-side pins plus the packet handoff to the laser transmit path.
// master: the packet reader; slave: the FTDI chip / downstream side.
interface ftdi_pkt_reader_if #(
    parameter int PKT_LEN = 8
);
    logic                   rxf_n;
    logic                   rd_n;
    logic [7:0]             adbus_in;
    logic                   bus_grant;
    logic                   bus_busy;
    logic [PKT_LEN*8-1:0]   pkt_data;
    logic                   pkt_is_stop;
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic                   hdr_err;

    modport master (
        input  rxf_n, adbus_in, bus_grant, pkt_ready,
        output rd_n, bus_busy, pkt_data, pkt_is_stop, pkt_valid, hdr_err
    );

    modport slave (
        output rxf_n, adbus_in, bus_grant, pkt_ready,
        input  rd_n, bus_busy, pkt_data, pkt_is_stop, pkt_valid, hdr_err
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to 1 so an active-low FTDI flag reads
// "not ready" until the first real sample arrives.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // two back-to-back flops, asynchronously preset on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ftdi_pkt_reader.sv
// Drains bytes from the FT232H async FIFO and frames them into START/STOP
// packets, handing each complete packet downstream on valid/ready.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | waiting for RXF#, bus grant and an empty packet slot
//  ST_RD_LOW  | RD# held low; ADBUS sampled on the last low cycle
//  ST_RD_HIGH | RD# high guard; sampled byte processed on the first cycle
//  ST_HOLD    | packet complete, pkt_valid high, no reads until accepted
module ftdi_pkt_reader #(
    parameter int         PKT_LEN        = laserdrop_pkg::START_PKT_LEN,
    parameter int         STOP_PKT_LEN   = laserdrop_pkg::STOP_PKT_LEN,
    parameter logic [7:0] START_SEQ      = laserdrop_pkg::START_SEQ,
    parameter logic [7:0] STOP_SEQ       = laserdrop_pkg::STOP_SEQ,
    parameter int         RD_LOW_CYCLES  = laserdrop_pkg::RD_LOW_CYCLES_DEF,
    parameter int         RD_HIGH_CYCLES = laserdrop_pkg::RD_HIGH_CYCLES_DEF
) (
    input logic               clock,
    input logic               reset,
    ftdi_pkt_reader_if.master bus
);
    import laserdrop_pkg::*;

    localparam int TMAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(PKT_LEN + 1);

    rd_state_e            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 rd_n_q, rd_n_d;
    logic                 busy_q, busy_d;
    logic                 proc_q, proc_d;
    logic [7:0]           byte_q, byte_d;

    logic [CW-1:0]        count_q;
    logic [CW-1:0]        len_q;
    logic [PKT_LEN*8-1:0] data_q;
    logic                 is_stop_q;
    logic                 valid_q;
    logic                 hdr_err_q;

    logic                 rxf_s;
    logic                 accept;
    logic                 pkt_full;
    logic                 guard_done;

    sync2 u_rxf_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.rxf_n),
        .q     (rxf_s)
    );

    assign accept     = valid_q & bus.pkt_ready;
    // len_q is 0 only before the first header, so a zero count never looks complete
    assign pkt_full   = (len_q != '0) && (count_q == len_q);
    assign guard_done = (state_q == ST_RD_HIGH) && (timer_q == '0);

    // state register and registered strobe outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            rd_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            proc_q  <= 1'b0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rd_n_q  <= rd_n_d;
            busy_q  <= busy_d;
            proc_q  <= proc_d;
            byte_q  <= byte_d;
        end
    end

    // next-state, read-strobe timing and byte capture
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rd_n_d  = rd_n_q;
        busy_d  = busy_q;
        proc_d  = 1'b0;
        byte_d  = byte_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxf_s && bus.bus_grant && !valid_q) begin
                    state_d = ST_RD_LOW;
                    rd_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    timer_d = TW'(RD_LOW_CYCLES - 1);
                end
            end
            ST_RD_LOW: begin
                // RXF# and bus_grant are deliberately ignored here: a started read always completes
                if (timer_q == '0) begin
                    state_d = ST_RD_HIGH;
                    byte_d  = bus.adbus_in;
                    proc_d  = 1'b1;
                    rd_n_d  = 1'b1;
                    timer_d = TW'(RD_HIGH_CYCLES - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_RD_HIGH: begin
                if (timer_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = pkt_full ? ST_HOLD : ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // packet assembly, header hunting and the downstream handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            len_q     <= '0;
            data_q    <= '0;
            is_stop_q <= 1'b0;
            valid_q   <= 1'b0;
            hdr_err_q <= 1'b0;
        end else begin
            hdr_err_q <= 1'b0;
            if (proc_q) begin
                if (count_q == '0) begin
                    if (byte_q == START_SEQ) begin
                        data_q       <= '0;
                        data_q[7:0]  <= byte_q;
                        len_q        <= CW'(PKT_LEN);
                        is_stop_q    <= 1'b0;
                        count_q      <= CW'(1);
                    end else if (byte_q == STOP_SEQ) begin
                        data_q       <= '0;
                        data_q[7:0]  <= byte_q;
                        len_q        <= CW'(STOP_PKT_LEN);
                        is_stop_q    <= 1'b1;
                        count_q      <= CW'(1);
                    end else begin
                        // unknown header: drop it and keep hunting
                        hdr_err_q <= 1'b1;
                    end
                end else begin
                    for (int i = 1; i < PKT_LEN; i++) begin
                        if (count_q == CW'(i)) begin
                            data_q[i*8 +: 8] <= byte_q;
                        end
                    end
                    count_q <= count_q + 1'b1;
                end
            end
            if (guard_done && pkt_full) begin
                valid_q <= 1'b1;
            end
            if (accept) begin
                valid_q <= 1'b0;
                count_q <= '0;
            end
        end
    end

    assign bus.rd_n        = rd_n_q;
    assign bus.bus_busy    = busy_q;
    assign bus.pkt_data    = data_q;
    assign bus.pkt_is_stop = is_stop_q;
    assign bus.pkt_valid   = valid_q;
    assign bus.hdr_err     = hdr_err_q;

endmodule

// File: tb/tb_ftdi_pkt_reader.sv
// Bench for ftdi_pkt_reader: an FTDI FIFO model feeds bytes, expected packets
// are queued as bytes are queued and popped when the reader presents a packet.
module tb_ftdi_pkt_reader;

    typedef struct packed {
        logic [63:0] data;
        logic        is_stop;
    } pkt_t;

    logic clock;
    logic reset;

    ftdi_pkt_reader_if #(.PKT_LEN(8)) bus ();

    ftdi_pkt_reader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo[$];
    pkt_t       exp_q[$];

    int low_bad = 0, gap_bad = 0, pulses = 0;
    int low_run = 0, high_run = 99;
    logic rd_prev = 1'b1;
    int hdr_pulses = 0, hdr_cycles = 0;
    logic hdr_prev = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // FTDI FIFO model: RXF# low while bytes remain, ADBUS shows the head byte
    always @(negedge clock) begin
        bus.rxf_n    = (fifo.size() == 0);
        bus.adbus_in = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    // RD# rising edge consumes the head byte
    always @(posedge bus.rd_n) begin
        if (fifo.size() != 0) void'(fifo.pop_front());
    end

    // RD# pulse-width and guard monitor, plus hdr_err pulse monitor
    always @(negedge clock) begin
        if (reset) begin
            rd_prev  = 1'b1;
            low_run  = 0;
            high_run = 99;
        end else if (bus.rd_n === 1'b0) begin
            if (rd_prev) begin
                if (high_run < 3) gap_bad++;
                low_run = 0;
            end
            low_run++;
            rd_prev = 1'b0;
        end else begin
            if (!rd_prev) begin
                if (low_run != 2) low_bad++;
                pulses++;
                high_run = 0;
            end
            high_run++;
            rd_prev = 1'b1;
        end
        if (bus.hdr_err === 1'b1) begin
            hdr_cycles++;
            if (!hdr_prev) hdr_pulses++;
        end
        hdr_prev = (bus.hdr_err === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic queue_start(input logic [7:0] first, input bit expect_it);
        pkt_t p;
        p.data    = '0;
        p.is_stop = 1'b0;
        p.data[7:0] = 8'hA5;
        fifo.push_back(8'hA5);
        for (int i = 1; i < 8; i++) begin
            p.data[i*8 +: 8] = first + 8'(i - 1);
            fifo.push_back(first + 8'(i - 1));
        end
        if (expect_it) exp_q.push_back(p);
    endtask

    task automatic queue_stop(input logic [7:0] b1);
        pkt_t p;
        p.data      = '0;
        p.data[7:0] = 8'h5A;
        p.data[15:8] = b1;
        p.is_stop   = 1'b1;
        fifo.push_back(8'h5A);
        fifo.push_back(b1);
        exp_q.push_back(p);
    endtask

    task automatic take_pkt(input int budget, output bit got, output pkt_t act, output pkt_t expv);
        got = 1'b0;
        act = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (bus.pkt_valid === 1'b1) begin
                got = 1'b1;
                act = {bus.pkt_data, bus.pkt_is_stop};
                break;
            end
        end
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++; if (bus.rd_n !== 1'b1) begin bad++; $display("FAIL reset_rd_n: got %b want 1", bus.rd_n); end
        total++; if (bus.bus_busy !== 1'b0) begin bad++; $display("FAIL reset_bus_busy: got %b want 0", bus.bus_busy); end
        total++; if (bus.pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_pkt_valid: got %b want 0", bus.pkt_valid); end
        total++; if (bus.pkt_is_stop !== 1'b0) begin bad++; $display("FAIL reset_pkt_is_stop: got %b want 0", bus.pkt_is_stop); end
        total++; if (bus.hdr_err !== 1'b0) begin bad++; $display("FAIL reset_hdr_err: got %b want 0", bus.hdr_err); end
        total++; if (bus.pkt_data !== 64'h0) begin bad++; $display("FAIL reset_pkt_data: got %h want 0", bus.pkt_data); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_start();
        bit got; pkt_t act, expv; int p0;
        p0 = pulses;
        queue_start(8'h01, 1'b1);
        take_pkt(300, got, act, expv);
        total++;
        if (!got) begin bad++; $display("FAIL start_timeout: no pkt_valid within budget"); end
        else if (act.data !== 64'h0706050403020100 + 64'hA5) begin
            bad++; $display("FAIL start_data: got %h want %h", act.data, 64'h07060504030201A5);
        end
        total++; if (act.data !== expv.data || act.is_stop !== 1'b0) begin
            bad++; $display("FAIL start_scoreboard: got %h/%b want %h/0", act.data, act.is_stop, expv.data);
        end
        @(negedge clock);
        total++; if (bus.pkt_valid !== 1'b0) begin bad++; $display("FAIL start_valid_width: valid still %b next cycle, want 0", bus.pkt_valid); end
        total++; if (pulses - p0 != 8) begin bad++; $display("FAIL start_rd_pulses: got %0d want 8", pulses - p0); end
    endtask

    task automatic test_stop();
        bit got; pkt_t act, expv;
        queue_stop(8'h01);
        take_pkt(200, got, act, expv);
        total++;
        if (!got) begin bad++; $display("FAIL stop_timeout: no pkt_valid within budget"); end
        else if (act.is_stop !== 1'b1) begin bad++; $display("FAIL stop_flag: got %b want 1", act.is_stop); end
        total++; if (act.data !== expv.data) begin bad++; $display("FAIL stop_data: got %h want %h", act.data, expv.data); end
    endtask

    task automatic test_resync();
        bit got; pkt_t act, expv; int h0, c0;
        h0 = hdr_pulses; c0 = hdr_cycles;
        fifo.push_back(8'h33);
        queue_start(8'h11, 1'b1);
        take_pkt(300, got, act, expv);
        total++;
        if (!got) begin bad++; $display("FAIL resync_timeout: no pkt_valid within budget"); end
        else if (act !== expv) begin bad++; $display("FAIL resync_pkt: got %h/%b want %h/%b", act.data, act.is_stop, expv.data, expv.is_stop); end
        total++; if (hdr_pulses - h0 != 1) begin bad++; $display("FAIL resync_hdr_pulses: got %0d want 1", hdr_pulses - h0); end
        total++; if (hdr_cycles - c0 != 1) begin bad++; $display("FAIL resync_hdr_width: got %0d want 1", hdr_cycles - c0); end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        bit got; pkt_t act, expv; logic [63:0] held; int errs; int gap;
        bus.pkt_ready = 1'b0;
        queue_start(8'h21, 1'b1);
        queue_stop(8'h77);
        take_pkt(300, got, act, expv);
        total++;
        if (!got) begin bad++; $display("FAIL bp_timeout: no pkt_valid within budget"); end
        else if (act !== expv) begin bad++; $display("FAIL bp_first_pkt: got %h want %h", act.data, expv.data); end
        held = act.data;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.rd_n !== 1'b1 || bus.pkt_valid !== 1'b1 || bus.pkt_data !== held) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_hold: %0d cycles with a read or unstable packet, want 0", errs); end
        bus.pkt_ready = 1'b1;
        @(negedge clock);
        total++; if (bus.pkt_valid !== 1'b0) begin bad++; $display("FAIL bp_release: pkt_valid %b after accept, want 0", bus.pkt_valid); end
        gap = 0;
        while (bus.rd_n !== 1'b0 && gap < 10) begin
            @(negedge clock);
            gap++;
        end
        total++; if (gap < 1 || gap >= 10) begin bad++; $display("FAIL bp_next_read: rd_n fell %0d cycles after valid fell, want 1..9", gap); end
        take_pkt(200, got, act, expv);
        total++;
        if (!got) begin bad++; $display("FAIL bp_second_timeout: no pkt_valid within budget"); end
        else if (act !== expv) begin bad++; $display("FAIL bp_second_pkt: got %h/%b want %h/%b", act.data, act.is_stop, expv.data, expv.is_stop); end
        @(negedge clock);
    endtask

    task automatic test_arbitration();
        bit got; pkt_t act, expv; int errs; int w;
        bus.bus_grant = 1'b0;
        queue_stop(8'h42);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.rd_n !== 1'b1) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL arb_no_grant: rd_n low %0d cycles, want 0", errs); end
        bus.bus_grant = 1'b1;
        w = 0;
        while (bus.rd_n !== 1'b0 && w < 20) begin
            @(negedge clock);
            w++;
        end
        bus.bus_grant = 1'b0;
        total++; if (w >= 20) begin bad++; $display("FAIL arb_start_timeout: rd_n never fell within %0d cycles", w); end
        repeat (20) @(negedge clock);
        total++; if (fifo.size() != 1 || bus.rd_n !== 1'b1) begin
            bad++; $display("FAIL arb_byte_done: fifo left %0d rd_n %b, want 1 and 1", fifo.size(), bus.rd_n);
        end
        bus.bus_grant = 1'b1;
        take_pkt(200, got, act, expv);
        total++;
        if (!got) begin bad++; $display("FAIL arb_timeout: no pkt_valid within budget"); end
        else if (act !== expv) begin bad++; $display("FAIL arb_pkt: got %h/%b want %h/%b", act.data, act.is_stop, expv.data, expv.is_stop); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        bit got; pkt_t act, expv; int p0; int w;
        p0 = pulses;
        queue_start(8'h51, 1'b0);
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!((pulses - p0) >= 3 && bus.rd_n === 1'b0) && w < 200);
        total++; if (w >= 200) begin bad++; $display("FAIL rstmid_wait: fourth read never started, pulses=%0d", pulses - p0); end
        #1 reset = 1'b1;
        #1;
        total++; if (bus.rd_n !== 1'b1) begin bad++; $display("FAIL rstmid_rd_n: got %b want 1 during reset", bus.rd_n); end
        fifo.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        queue_stop(8'h09);
        take_pkt(200, got, act, expv);
        total++;
        if (!got) begin bad++; $display("FAIL rstmid_timeout: no pkt_valid within budget"); end
        else if (act.data !== 64'h095A || act.is_stop !== 1'b1) begin
            bad++; $display("FAIL rstmid_pkt: got %h/%b want %h/1", act.data, act.is_stop, 64'h095A);
        end
        @(negedge clock);
    endtask

    task automatic test_timing();
        total++; if (low_bad != 0) begin bad++; $display("FAIL rd_low_width: %0d pulses not 2 cycles", low_bad); end
        total++; if (gap_bad != 0) begin bad++; $display("FAIL rd_high_gap: %0d gaps under 3 cycles", gap_bad); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.bus_grant = 1'b1;
        bus.pkt_ready = 1'b1;
        test_reset();
        test_start();
        test_stop();
        test_resync();
        test_backpressure();
        test_arbitration();
        test_reset_mid();
        test_timing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ftdi_pkt_reader.md
Name: ftdi_pkt_reader

Overview:
- Upstream stage of the laser link. Drains bytes from the FT232H async-FIFO read side (RXF#/RD#/ADBUS) and frames them into START or STOP packets.
- Hands each complete packet to the laser transmit path over a valid/ready handshake.
- Shares ADBUS with the FTDI write path; arbitration is through `bus_grant`/`bus_busy`.

Parameters:
- PKT_LEN, 8: total START packet length in bytes, header byte included (≥2).
- STOP_PKT_LEN, 2: total STOP packet length in bytes, header byte included (≥2, ≤PKT_LEN).
- START_SEQ, 8'hA5: header byte that marks a START packet.
- STOP_SEQ, 8'h5A: header byte that marks a STOP packet.
- RD_LOW_CYCLES, 2: cycles `rd_n` is held low before ADBUS is sampled (≥1).
- RD_HIGH_CYCLES, 3: minimum cycles `rd_n` is held high between bytes (≥3, covers the 2-flop RXF# synchronizer).

Ports:
- `clock` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `rxf_n` in 1: FTDI RXF#, asynchronous; low means a byte is available.
- `rd_n` out 1: FTDI RD#, active low.
- `adbus_in` in 8: ADBUS input value.
- `bus_grant` in 1: ADBUS may be used for reads.
- `bus_busy` out 1: high from `rd_n` falling until the end of the RD_HIGH guard.
- `pkt_data` out PKT_LEN×8: packed bytes; byte i is at [8i+7:8i]; byte 0 is the header.
- `pkt_is_stop` out 1: the held packet is a STOP packet.
- `pkt_valid` out 1: a packet is held and ready for transfer.
- `pkt_ready` in 1: downstream accepts the packet.
- `hdr_err` out 1: one-cycle pulse when a header byte is discarded.

Behaviour:
- Reset values: `rd_n`=1, `bus_busy`=0, `pkt_valid`=0, `pkt_is_stop`=0, `hdr_err`=0, `pkt_data`=0. Byte count, expected length and timers all reset to 0. FSM resets to IDLE.
- `rxf_n` passes through a 2-flop synchronizer, resetting to 1, giving `rxf_s`. There is no other CDC.
- **IDLE**
  - If `rxf_s`=0, `bus_grant`=1 and `pkt_valid`=0: go to RD_LOW.
  - On that transition, `rd_n` goes to 0 and `bus_busy` goes to 1, both registered outputs.
- **RD_LOW**
  - Holds `rd_n`=0 for exactly RD_LOW_CYCLES cycles.
  - `adbus_in` is registered on the last of those cycles.
  - Next state is RD_HIGH with `rd_n`=1.
- **RD_HIGH**
  - Holds `rd_n`=1 for RD_HIGH_CYCLES cycles.
  - The sampled byte is processed on the first cycle; `bus_busy` drops on exit.
  - Next state: HOLD if the packet is complete, otherwise IDLE.
- **Byte processing, count=0 (header)**
  - START_SEQ: store at byte 0, expected length = PKT_LEN, `pkt_is_stop`=0.
  - STOP_SEQ: store at byte 0, expected length = STOP_PKT_LEN, `pkt_is_stop`=1.
  - Any other value: discard, pulse `hdr_err` for one cycle, count stays 0 (resync hunting).
- **Byte processing, count>0**
  - Store at byte[count], then count+1.
  - When count+1 equals the expected length, the packet is complete.
- **HOLD**
  - `pkt_valid`=1; `pkt_data` and `pkt_is_stop` are stable.
  - Unused upper bytes of a STOP packet read 0; the buffer is cleared at each header.
  - No reads are issued while in HOLD (backpressure to the FTDI).
  - On `pkt_valid`&`pkt_ready`: `pkt_valid`=0 next cycle, count=0, go to IDLE.
  - The earliest next `rd_n` fall is one cycle after acceptance.
- `bus_grant` is only checked in IDLE. Deasserting it mid-byte does not abort the current byte; a byte read is never truncated.
- `rxf_s` rising during RD_LOW is ignored; the byte is still sampled.
- Minimum byte period is RD_LOW_CYCLES + RD_HIGH_CYCLES + 1 = 6 cycles at the defaults.
- Reset asserted mid-byte or mid-packet:
  - `rd_n` goes high immediately (asynchronous).
  - The partial packet is discarded.
  - The first byte after reset is treated as a header.
- `pkt_ready` asserted while `pkt_valid`=0 has no effect.

Decomposition:
- Shared package `laserdrop_pkg`: START_SEQ, STOP_SEQ, ACK_SEQ, DONE_SEQ, START_PKT_LEN, STOP_PKT_LEN constants, plus the reader state enum.
- Parameter defaults are taken from the package.
- One natural sub-module: `sync2`, a 2-flop synchronizer with asynchronous reset value 1, reusable for `txe_n` in the writer.

Test Plan:
- START packet: model supplies A5,01,02,...,07 with RXF# low, `bus_grant`=1, `pkt_ready`=1.
  - Expect `pkt_valid` for 1 cycle, `pkt_data` = 07_06_05_04_03_02_01_A5, `pkt_is_stop`=0.
  - Expect each `rd_n` low pulse to be exactly 2 cycles, with ≥3 high cycles between pulses.
- STOP packet: supply 5A,01.
  - Expect `pkt_is_stop`=1 and `pkt_data` bytes 0–1 = 5A,01, all others 00.
- Resync: supply 33, then a full START packet.
  - Expect one `hdr_err` pulse, then a correct packet with byte0=A5.
- Backpressure: `pkt_ready`=0 for 50 cycles after a packet while RXF# stays low.
  - Expect `rd_n` to stay 1 and `pkt_data` to stay stable.
  - Raise `pkt_ready`: expect `pkt_valid` to fall next cycle and the next `rd_n` fall ≥1 cycle later.
- Arbitration: `bus_grant`=0 with RXF# low → `rd_n` stays 1. Drop `bus_grant` during RD_LOW → the byte completes and is stored.
- Reset mid-packet: after 3 of 8 bytes, pulse `reset`.
  - Expect `rd_n`=1 immediately.
  - Then supply 5A,09: expect a STOP packet with byte1=09.
